// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared prescaler, period counter, per-channel duty, double-buffered registers.
// Latency: register writes reach shadows next edge; pwm_out/period_start are registered from this edge's cnt.
// Backpressure: none; one write accepted per wr_en cycle. Optional triangle counter via PWM_CENTER_ALIGN_EN.
module pwm_multi_channel #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int ADDR_W = $clog2(NUM_CH + 2)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_start
);

   localparam logic [ADDR_W-1:0] PERIOD_ADDR   = ADDR_W'(NUM_CH);
   localparam logic [ADDR_W-1:0] PRESCALE_ADDR = ADDR_W'(NUM_CH + 1);
   localparam logic [WIDTH-1:0]  PERIOD_RST    = '1;
   localparam logic [WIDTH-1:0]  DUTY_RST      = WIDTH'(2 ** (WIDTH - 1));

   logic [WIDTH-1:0]  pre_cnt, pre_cnt_nxt;
   logic [WIDTH-1:0]  prescale, prescale_nxt;
   logic [WIDTH-1:0]  cnt, cnt_nxt;
   logic [WIDTH-1:0]  period_sh, period_sh_nxt;
   logic [WIDTH-1:0]  period_act, period_act_nxt;
   logic [WIDTH-1:0]  duty_sh      [NUM_CH];
   logic [WIDTH-1:0]  duty_sh_nxt  [NUM_CH];
   logic [WIDTH-1:0]  duty_act     [NUM_CH];
   logic [WIDTH-1:0]  duty_act_nxt [NUM_CH];
   logic [NUM_CH-1:0] pwm_nxt;
   logic              tick;
   logic              wrap;
   logic              load;
`ifdef PWM_CENTER_ALIGN_EN
   logic              dir_down, dir_down_nxt;
`endif

   // Register-file writes land in the shadows; prescale has no shadow and is used as soon as it is stored.
   always_comb begin
      period_sh_nxt = period_sh;
      prescale_nxt  = prescale;
      for (int i = 0; i < NUM_CH; i++) begin
         duty_sh_nxt[i] = duty_sh[i];
      end
      if (wr_en) begin
         if (wr_addr == PERIOD_ADDR)   period_sh_nxt = wr_data;
         if (wr_addr == PRESCALE_ADDR) prescale_nxt  = wr_data;
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_addr == ADDR_W'(i)) duty_sh_nxt[i] = wr_data;
         end
      end
   end

   // Prescaler and period counter; wrap marks the period boundary.
   always_comb begin
      tick        = enable && (pre_cnt >= prescale);
      pre_cnt_nxt = '0;
      cnt_nxt     = '0;
      wrap        = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_down_nxt = 1'b0;
`endif
      if (enable) begin
         // >= rather than == so a prescale shrunk below pre_cnt still ticks next cycle
         pre_cnt_nxt = tick ? '0 : pre_cnt + 1'b1;
         cnt_nxt     = cnt;
`ifdef PWM_CENTER_ALIGN_EN
         dir_down_nxt = dir_down;
         if (tick) begin
            if (period_act == '0) begin
               cnt_nxt      = '0;
               wrap         = 1'b1;
               dir_down_nxt = 1'b0;
            end else if (!dir_down && (cnt != period_act)) begin
               cnt_nxt = cnt + 1'b1;
            end else begin
               // at the top or already descending; the period ends on arrival at zero
               cnt_nxt      = cnt - 1'b1;
               wrap         = (cnt == WIDTH'(1));
               dir_down_nxt = !wrap;
            end
         end
`else
         if (tick) begin
            if (cnt == period_act) begin
               cnt_nxt = '0;
               wrap    = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
`endif
      end
   end

   // Shadow-to-active load at the boundary (or continuously while stopped), then compare on the new values.
   always_comb begin
      load           = wrap || !enable;
      period_act_nxt = load ? period_sh_nxt : period_act;
      for (int i = 0; i < NUM_CH; i++) begin
         duty_act_nxt[i] = load ? duty_sh_nxt[i] : duty_act[i];
         pwm_nxt[i]      = enable && (cnt_nxt < duty_act_nxt[i]);
      end
   end

   // State registers with synchronous reset; reset discards any pending shadow writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt      <= '0;
         prescale     <= '0;
         cnt          <= '0;
         period_sh    <= PERIOD_RST;
         period_act   <= PERIOD_RST;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_sh[i]  <= DUTY_RST;
            duty_act[i] <= DUTY_RST;
         end
         pwm_out      <= '0;
         period_start <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         dir_down     <= 1'b0;
`endif
      end else begin
         pre_cnt      <= pre_cnt_nxt;
         prescale     <= prescale_nxt;
         cnt          <= cnt_nxt;
         period_sh    <= period_sh_nxt;
         period_act   <= period_act_nxt;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_sh[i]  <= duty_sh_nxt[i];
            duty_act[i] <= duty_act_nxt[i];
         end
         pwm_out      <= pwm_nxt;
         period_start <= wrap;
`ifdef PWM_CENTER_ALIGN_EN
         dir_down     <= dir_down_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel (default sawtooth build): table of programmed scenarios with
// measured period/high-time, hand-written double-buffer and reset sequences, and random
// register traffic compared every cycle against a reference model.
module tb_pwm_multi_channel;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] pwm_out;
   logic       period_start;

   int checks   = 0;
   int failures = 0;

   pwm_multi_channel #(.NUM_CH(4), .WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .pwm_out      (pwm_out),
      .period_start (period_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int       m_pre, m_cnt, m_ps, m_pact, m_psh;
   int       m_dact [4];
   int       m_dsh  [4];
   bit [3:0] m_out;
   bit       m_pstart;

   function automatic void model_step();
      int  psh_n;
      int  ps_n;
      int  dsh_n [4];
      bit  tk;
      bit  wr;
      if (reset) begin
         m_pre = 0; m_cnt = 0; m_ps = 0; m_psh = 255; m_pact = 255;
         for (int i = 0; i < 4; i++) begin m_dsh[i] = 128; m_dact[i] = 128; end
         m_out = '0; m_pstart = 1'b0;
         return;
      end
      psh_n = m_psh; ps_n = m_ps; dsh_n = m_dsh;
      if (wr_en) begin
         if (wr_addr < 4)       dsh_n[wr_addr] = int'(wr_data);
         else if (wr_addr == 4) psh_n = int'(wr_data);
         else if (wr_addr == 5) ps_n  = int'(wr_data);
      end
      if (!enable) begin
         m_pre = 0; m_cnt = 0; m_out = '0; m_pstart = 1'b0;
         m_pact = psh_n; m_dact = dsh_n;
      end else begin
         tk = (m_pre >= m_ps);
         wr = tk && (m_cnt == m_pact);
         m_pre = tk ? 0 : m_pre + 1;
         if (wr) begin
            m_cnt = 0; m_pact = psh_n; m_dact = dsh_n;
         end else if (tk) begin
            m_cnt = m_cnt + 1;
         end
         m_pstart = wr;
         for (int i = 0; i < 4; i++) m_out[i] = (m_cnt < m_dact[i]);
      end
      m_psh = psh_n; m_ps = ps_n; m_dsh = dsh_n;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // one clock: model advances on the same edge, outputs sampled 1ns later
   task automatic tick_clk();
      @(posedge clk);
      model_step();
      #1;
      checks++;
      if (pwm_out !== m_out || period_start !== m_pstart) begin
         failures++;
         $display("FAIL lockstep t=%0t: pwm_out=%b period_start=%b expected pwm_out=%b period_start=%b",
                  $time, pwm_out, period_start, m_out, m_pstart);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick_clk();
      wr_en = 1'b0;
   endtask

   // measure one full period: from a period_start sample up to (excluding) the next
   int meas_int;
   int meas_hi [4];
   bit meas_ok;

   task automatic measure(input int wr_off, input logic [2:0] a, input logic [7:0] d);
      int guard;
      meas_ok  = 1'b0;
      meas_int = 0;
      for (int i = 0; i < 4; i++) meas_hi[i] = 0;
      guard = 0;
      do begin
         tick_clk();
         guard++;
      end while (period_start !== 1'b1 && guard < 3000);
      if (period_start !== 1'b1) begin
         chk("period_start_timeout", 0, 1);
         return;
      end
      guard = 0;
      do begin
         for (int i = 0; i < 4; i++) if (pwm_out[i]) meas_hi[i]++;
         if (meas_int == wr_off) begin
            wr_en = 1'b1; wr_addr = a; wr_data = d;
         end
         meas_int++;
         tick_clk();
         wr_en = 1'b0;
         guard++;
      end while (period_start !== 1'b1 && guard < 3000);
      if (period_start !== 1'b1) begin
         chk("period_end_timeout", 0, 1);
         return;
      end
      meas_ok = 1'b1;
   endtask

   typedef struct {
      int ps;
      int per;
      int duty   [4];
      int exp_int;
      int exp_hi [4];
   } vec_t;

   vec_t tbl [5];

   task automatic set_row(input int idx, input int ps, input int per,
                          input int d0, input int d1, input int d2, input int d3,
                          input int ei, input int h0, input int h1, input int h2, input int h3);
      tbl[idx].ps = ps; tbl[idx].per = per;
      tbl[idx].duty[0] = d0; tbl[idx].duty[1] = d1; tbl[idx].duty[2] = d2; tbl[idx].duty[3] = d3;
      tbl[idx].exp_int = ei;
      tbl[idx].exp_hi[0] = h0; tbl[idx].exp_hi[1] = h1; tbl[idx].exp_hi[2] = h2; tbl[idx].exp_hi[3] = h3;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick_clk();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

      // ---- reset state ----
      do_reset();
      chk("reset_pwm_out", int'(pwm_out), 0);
      chk("reset_period_start", int'(period_start), 0);

      // ---- table-driven scenarios ----
      //          ps per  duty0..3          interval  high0..3
      set_row(0, 0, 255, 128, 128, 128, 128, 256, 128, 128, 128, 128);
      set_row(1, 0,   9,   0,   3,  10, 128,  10,   0,   3,  10,  10);
      set_row(2, 2,   4,   2,   0,   5,   1,  15,   6,   0,  15,   3);
      set_row(3, 1,   0,   0,   1,   5,   0,   2,   0,   2,   2,   0);
      set_row(4, 3,   2,   1,   2,   3, 255,  12,   4,   8,  12,  12);

      for (int r = 0; r < 5; r++) begin
         enable = 1'b0;
         do_reset();
         if (r != 0) begin
            wr(3'd5, 8'(tbl[r].ps));
            wr(3'd4, 8'(tbl[r].per));
            for (int c = 0; c < 4; c++) wr(3'(c), 8'(tbl[r].duty[c]));
         end
         enable = 1'b1;
         measure(-1, 3'd0, 8'd0);
         if (meas_ok) begin
            chk($sformatf("row%0d_interval", r), meas_int, tbl[r].exp_int);
            for (int c = 0; c < 4; c++)
               chk($sformatf("row%0d_high_ch%0d", r, c), meas_hi[c], tbl[r].exp_hi[c]);
         end
      end

      // ---- double buffering: mid-period write vs write in the wrap cycle ----
      enable = 1'b0;
      do_reset();
      wr(3'd4, 8'd9);
      wr(3'd1, 8'd3);
      enable = 1'b1;
      measure(-1, 3'd0, 8'd0);
      measure(5, 3'd1, 8'd1);
      if (meas_ok) chk("midwrite_old_duty_kept", meas_hi[1], 3);
      measure(-1, 3'd0, 8'd0);
      if (meas_ok) chk("midwrite_new_duty_next_period", meas_hi[1], 1);
      measure(9, 3'd1, 8'd7);
      if (meas_ok) chk("wrapwrite_current_period", meas_hi[1], 1);
      measure(-1, 3'd0, 8'd0);
      if (meas_ok) chk("wrapwrite_applies_new_period", meas_hi[1], 7);

      // ---- reset mid-period with a pending shadow write ----
      measure(-1, 3'd0, 8'd0);
      for (int k = 0; k < 6; k++) tick_clk();
      wr(3'd0, 8'd2);
      reset = 1'b1;
      tick_clk();
      reset = 1'b0;
      chk("midreset_pwm_out", int'(pwm_out), 0);
      chk("midreset_period_start", int'(period_start), 0);
      measure(-1, 3'd0, 8'd0);
      if (meas_ok) begin
         chk("midreset_interval", meas_int, 256);
         chk("midreset_ch0_pending_lost", meas_hi[0], 128);
         chk("midreset_ch1_default", meas_hi[1], 128);
      end

      // ---- randomized register traffic against the model ----
      for (int n = 0; n < 4000; n++) begin
         reset  = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         wr_en   = ($urandom_range(0, 7) == 0);
         wr_addr = 3'($urandom_range(0, 7));
         case (wr_addr)
            3'd4:    wr_data = 8'($urandom_range(0, 12));
            3'd5:    wr_data = 8'($urandom_range(0, 3));
            default: wr_data = 8'($urandom_range(0, 14));
         endcase
         tick_clk();
      end
      reset = 1'b0; wr_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
